mig1_fetch_unit: RTL and testbench
==================================

# mig1_fetch_unit

Instruction fetch stage for the Mig1 CPU. It owns the fetch PC, issues word reads to the synchronous SimRAM read port, buffers returned words in a small prefetch queue, and delivers instructions with their PC to the Mig1 core's decode over a valid/ready handshake. A redirect input from the core flushes the queue and any in-flight read, then restarts fetch at a new word address.

## Interface
- `DATA_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, 8: byte address width. Fetch addresses are word-aligned, so bits [1:0] are always 0.
- `DEPTH`, 4: prefetch queue entries, a power of two, at least 2.

- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `rst_addr`, input, [ADDR_WIDTH-1:2]: boot word address, sampled in BOOT.
- `mem_rd_en`, output, 1: RAM read request for this cycle.
- `mem_rd_addr`, output, ADDR_WIDTH: RAM byte address; bits [1:0] are 0.
- `mem_rd_data`, input, DATA_WIDTH: RAM data, valid exactly 1 cycle after `mem_rd_en`.
- `redirect_valid`, input, 1: the core requests a fetch restart.
- `redirect_addr`, input, [ADDR_WIDTH-1:2]: restart word address.
- `insn_valid`, output, 1: the queue head is valid.
- `insn_ready`, input, 1: decode accepts the head.
- `insn_data`, output, DATA_WIDTH: head instruction.
- `insn_pc`, output, ADDR_WIDTH: byte address of the head instruction.
- `fetch_pc`, output, ADDR_WIDTH: next address to fetch, for DPI/debug.

## Operation
- FSM states: RESET, BOOT, RUN.
  - RESET: held while `rst` is 0.
  - RESET → BOOT on the first clock edge after `rst` rises.
  - BOOT → RUN on the following edge.
- BOOT:
  - `pc <= {rst_addr, 2'b00}`.
  - No read is issued.
  - The queue is empty and `epoch` is cleared.
- RUN, issue rule: `mem_rd_en = (count + pend < DEPTH) && !redirect_valid`.
  - `pend` is 1 when a read was issued in the previous cycle.
  - `mem_rd_addr = pc`.
  - On issue, `pc <= pc + 4`.
- Each issue records `{pc, epoch}` in a 1-deep in-flight register.
  - Next cycle, if the recorded epoch equals the current `epoch`, `{mem_rd_data, pc}` is pushed into the queue.
  - Otherwise the response is dropped.
- Pop: when `insn_valid && insn_ready`. A push and a pop in the same cycle are both honoured and `count` is unchanged.
- Redirect (`redirect_valid` = 1 in RUN):
  - Effects:
    - Queue is flushed (`count <= 0`).
    - `epoch` toggles.
    - `pc <= {redirect_addr, 2'b00}`.
    - No issue that cycle.
    - A pop in the same cycle is ignored.
  - Priority: redirect beats push, pop and issue.
  - Fetch resumes at the new PC on the next cycle.
- Redirect in BOOT: ignored.
- PC arithmetic: modulo 2^ADDR_WIDTH, so 0xFC + 4 = 0x00 with no error.
- The queue never overflows, because the issue rule reserves an entry for every pending read.

## Timing
- Reset values:
  - `mem_rd_en` = 0, `mem_rd_addr` = 0, `fetch_pc` = 0.
  - `insn_valid` = 0, `insn_data` = 0, `insn_pc` = 0.
  - `count` = 0, `pend` = 0, `epoch` = 0.
- First issue: in the first RUN cycle, which is 2 cycles after reset release.
- Latency from issue in cycle N:
  - Data returns in cycle N+1.
  - Queue push at the end of N+1.
  - `insn_valid` in cycle N+2.
- Throughput: 1 instruction per cycle when `insn_ready` is held at 1.
- Redirect asserted in cycle R:
  - `insn_valid` = 0 in R+1.
  - Issue at the new address in R+1.
  - First new instruction is valid in R+3.
- Back-pressure: with `insn_ready` = 0, at most DEPTH reads are outstanding or queued, then `mem_rd_en` stays 0.
- Queue outputs are registered and come straight from the head entry, with no combinational path from `mem_rd_data`.
- Reset asserted mid-operation: all state clears immediately, asynchronously, and any in-flight response is lost.

## Structure
- Shared package `mig1_pkg`:
  - `MIG1_DATA_WIDTH`, `MIG1_ADDR_WIDTH`.
  - `mig1_addr_t`, `mig1_word_addr_t`, `mig1_insn_t`.
  - Fetch FSM state enum `mig1_fetch_state_e`.
- Sub-module `mig1_fetch_fifo`:
  - Parameterised by DEPTH and entry width, with the entry holding `{insn, pc}`.
  - Ports: push, pop, flush, count, head.
  - Asynchronous active-low reset.
- Top level: the FSM, PC, in-flight/epoch register and the issue rule.

## Test plan
- Boot: `rst_addr` = 0x04, `insn_ready` = 1, RAM word k = k.
  - Reads are issued at 0x10, 0x14, 0x18, …
  - `insn_valid` first rises 4 cycles after reset release, with `insn_pc` = 0x10 and `insn_data` = 4.
- Back-pressure: hold `insn_ready` = 0 for 10 cycles.
  - Exactly 4 reads are issued, then `mem_rd_en` = 0 and `count` = 4.
  - On release, 4 consecutive instructions drain in order with no gaps.
- Redirect with in-flight read: redirect to word 0x20 in the cycle after an issue.
  - The stale response is dropped.
  - The next `insn_pc` is 0x80.
  - No pre-redirect PC is ever delivered.
- Wrap-around: boot at word 0x3E.
  - Delivered PCs are 0xF8, 0xFC, 0x00, 0x04.
- Random `insn_ready` and redirect, 2000 cycles, checked against a reference PC model.
  - Every delivered `{pc, data}` pair matches RAM.
  - PCs are sequential between redirects.
  - `count` never exceeds 4.
- Reset asserted mid-stream with the queue full.
  - All outputs are 0 immediately.
  - After release, fetch restarts at `rst_addr`.

Source files
------------

// File: rtl/mig1_pkg.sv
// Shared definitions for the Mig1 fetch slice.
//   MIG1_DATA_WIDTH / MIG1_ADDR_WIDTH : default instruction and byte-address widths
//   mig1_addr_t      : byte address
//   mig1_word_addr_t : word address (byte address bits [ADDR_WIDTH-1:2])
//   mig1_insn_t      : instruction word
//   mig1_fetch_state_e : fetch FSM states
package mig1_pkg;

  localparam int unsigned MIG1_DATA_WIDTH = 32;
  localparam int unsigned MIG1_ADDR_WIDTH = 8;

  typedef logic [MIG1_ADDR_WIDTH-1:0] mig1_addr_t;
  typedef logic [MIG1_ADDR_WIDTH-1:2] mig1_word_addr_t;
  typedef logic [MIG1_DATA_WIDTH-1:0] mig1_insn_t;

  typedef enum logic [1:0] {
    FETCH_RESET = 2'd0,
    FETCH_BOOT  = 2'd1,
    FETCH_RUN   = 2'd2
  } mig1_fetch_state_e;

endpackage

// File: rtl/mig1_fetch_fifo.sv
// Prefetch queue for the Mig1 fetch unit.
//   clk, rst      : clock, asynchronous active-low reset
//   push, push_data : write one entry ({insn, pc})
//   pop           : retire the head entry (ignored when empty)
//   flush         : empty the queue; overrides push and pop
//   count         : number of valid entries (0..DEPTH)
//   head          : head entry, read straight from the storage registers
module mig1_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && (count != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mig1_fetch_unit.sv
// Mig1 instruction fetch stage.
//   clk, rst        : clock, asynchronous active-low reset
//   rst_addr        : boot word address, sampled in BOOT
//   mem_rd_en/addr  : synchronous RAM read request (data back one cycle later)
//   mem_rd_data     : RAM read data
//   redirect_valid/addr : restart fetch at a new word address (flushes queue)
//   insn_valid/ready/data/pc : instruction handshake towards decode
//   fetch_pc        : next address to fetch (debug)
module mig1_fetch_unit
  import mig1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MIG1_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = MIG1_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:2]   rst_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:2]   redirect_addr,
  output logic                    insn_valid,
  input  logic                    insn_ready,
  output logic [DATA_WIDTH-1:0]   insn_data,
  output logic [ADDR_WIDTH-1:0]   insn_pc,
  output logic [ADDR_WIDTH-1:0]   fetch_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(DEPTH);

  mig1_fetch_state_e     state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inf_pc;
  logic                  inf_epoch;
  logic                  pend;
  logic                  epoch;

  logic [CW-1:0]         q_count;
  logic [EW-1:0]         q_head;
  logic                  in_run;
  logic                  redirect;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic [CW:0]           occupancy;

  // Queued entries plus the read still in flight: each issued read owns a
  // slot before its data arrives, so the queue can never overflow.
  always_comb begin
    in_run    = (state == FETCH_RUN);
    redirect  = in_run && redirect_valid;
    occupancy = {1'b0, q_count} + {{CW{1'b0}}, pend};
    issue     = in_run && !redirect_valid && (occupancy < OCC_LIMIT);
    push      = pend && (inf_epoch == epoch) && !redirect;
    pop       = insn_valid && insn_ready && !redirect;
    flush     = redirect || (state == FETCH_BOOT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH_RESET;
      pc        <= '0;
      inf_pc    <= '0;
      inf_epoch <= 1'b0;
      pend      <= 1'b0;
      epoch     <= 1'b0;
    end else begin
      case (state)
        FETCH_RESET: begin
          state <= FETCH_BOOT;
        end
        FETCH_BOOT: begin
          pc    <= {rst_addr, 2'b00};
          epoch <= 1'b0;
          pend  <= 1'b0;
          state <= FETCH_RUN;
        end
        FETCH_RUN: begin
          pend <= issue;
          if (issue) begin
            inf_pc    <= pc;
            inf_epoch <= epoch;
            pc        <= pc + ADDR_WIDTH'(4);
          end
          // A response tagged with the old epoch is dropped when it returns.
          if (redirect_valid) begin
            epoch <= !epoch;
            pc    <= {redirect_addr, 2'b00};
          end
        end
        default: begin
          state <= FETCH_RESET;
        end
      endcase
    end
  end

  mig1_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mem_rd_data, inf_pc}),
    .pop       (pop),
    .flush     (flush),
    .count     (q_count),
    .head      (q_head)
  );

  assign mem_rd_en   = issue;
  assign mem_rd_addr = pc;
  assign fetch_pc    = pc;
  assign insn_valid  = (q_count != '0);
  assign insn_data   = q_head[EW-1:ADDR_WIDTH];
  assign insn_pc     = q_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_mig1_fetch_unit.sv
// Self-checking bench for mig1_fetch_unit: directed boot, back-pressure,
// redirect, wrap-around and mid-stream reset, then a randomized run checked
// against a delivered-PC reference model and a RAM image.
module tb_mig1_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:2]  rst_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        redirect_valid;
  logic [7:2]  redirect_addr;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn_data;
  logic [7:0]  insn_pc;
  logic [7:0]  fetch_pc;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ram [64];

  always #5 clk = ~clk;

  // Synchronous RAM read port: data one cycle after the request.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr[7:2]];
  end

  mig1_fetch_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rst_addr       (rst_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .fetch_pc       (fetch_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"},   32'(mem_rd_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    chk({tag, "_fetch_pc"},32'(fetch_pc),    32'd0);
    chk({tag, "_valid"},   32'(insn_valid),  32'd0);
    chk({tag, "_data"},    insn_data,        32'd0);
    chk({tag, "_pc"},      32'(insn_pc),     32'd0);
    chk({tag, "_count"},   32'(dut.q_count), 32'd0);
  endtask

  // Asserts reset for two cycles and releases it just after a rising edge.
  task automatic do_reset(input logic [5:0] a);
    rst            = 1'b0;
    rst_addr       = a;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    insn_ready     = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    int          issues;
    int          delivered;
    int          e;
    logic [5:0]  ra;
    logic [7:0]  exp_pc;
    logic        prev_redir;

    for (int k = 0; k < 64; k++) ram[k] = 32'(k);
    rst            = 1'b0;
    rst_addr       = 6'h04;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    insn_ready     = 1'b1;
    next_cycle();
    sample();
    check_reset_outputs("por");

    // Boot at word 0x04: first issue 2 cycles after release, first valid after 4.
    next_cycle();
    do_reset(6'h04);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      sample();
      chk("boot_rd_en", 32'(mem_rd_en), 32'(k >= 2));
      if (k >= 2) chk("boot_rd_addr", 32'(mem_rd_addr), 32'(8'h10 + 4 * (k - 2)));
      chk("boot_valid", 32'(insn_valid), 32'(k >= 4));
      if (k >= 4) begin
        chk("boot_pc",   32'(insn_pc), 32'(8'h10 + 4 * (k - 4)));
        chk("boot_data", insn_data,    32'(4 + (k - 4)));
      end
    end

    // Back-pressure from an empty queue: redirect to word 0x08, ready low.
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 6'h08;
    insn_ready     = 1'b0;
    sample();
    chk("bp_redirect_rd_en", 32'(mem_rd_en), 32'd0);
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      if (mem_rd_en) issues++;
    end
    chk("bp_issue_count", 32'(issues),      32'd4);
    chk("bp_rd_en_idle",  32'(mem_rd_en),   32'd0);
    chk("bp_count_full",  32'(dut.q_count), 32'd4);
    chk("bp_head_pc",     32'(insn_pc),     32'h20);
    for (int d = 0; d < 4; d++) begin
      next_cycle();
      insn_ready = 1'b1;
      sample();
      chk("drain_valid", 32'(insn_valid), 32'd1);
      chk("drain_pc",    32'(insn_pc),    32'(8'h20 + 4 * d));
      chk("drain_data",  insn_data,       32'(8 + d));
    end

    // Redirect to word 0x20 in the cycle after an issue.
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      sample();
    end
    chk("pre_redirect_issue", 32'(mem_rd_en), 32'd1);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 6'h20;
    sample();
    chk("redir_rd_en", 32'(mem_rd_en), 32'd0);
    for (int j = 1; j <= 4; j++) begin
      next_cycle();
      redirect_valid = 1'b0;
      sample();
      chk("redir_valid", 32'(insn_valid), 32'(j >= 3));
      if (j == 1) begin
        chk("redir_new_rd_en", 32'(mem_rd_en),   32'd1);
        chk("redir_new_addr",  32'(mem_rd_addr), 32'h80);
      end
      if (j >= 3) begin
        chk("redir_pc",   32'(insn_pc), 32'(8'h80 + 4 * (j - 3)));
        chk("redir_data", insn_data,    32'(8'h20 + (j - 3)));
      end
    end

    // Wrap-around: boot at word 0x3E.
    next_cycle();
    do_reset(6'h3E);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      sample();
      chk("wrap_valid", 32'(insn_valid), 32'(k >= 4));
      if (k >= 4) begin
        e = (8'hF8 + 4 * (k - 4)) % 256;
        chk("wrap_pc",   32'(insn_pc), 32'(e));
        chk("wrap_data", insn_data,    32'(e / 4));
      end
    end

    // Fill the queue, then reset mid-stream.
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      insn_ready = 1'b0;
      sample();
    end
    chk("full_count", 32'(dut.q_count), 32'd4);
    next_cycle();
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");

    // Randomized run from a random boot address against a delivered-PC model.
    for (int k = 0; k < 64; k++) ram[k] = $urandom;
    ra = 6'($urandom);
    rst_addr   = ra;
    insn_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    exp_pc     = {ra, 2'b00};
    prev_redir = 1'b0;
    delivered  = 0;
    for (int k = 1; k <= 2000; k++) begin
      next_cycle();
      insn_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = (k >= 3) && ($urandom_range(0, 15) == 0);
      redirect_addr  = 6'($urandom);
      sample();
      if (k == 2) begin
        chk("restart_rd_en", 32'(mem_rd_en),   32'd1);
        chk("restart_addr",  32'(mem_rd_addr), 32'({ra, 2'b00}));
      end
      chk("count_bound", 32'(dut.q_count <= 3'd4), 32'd1);
      if (prev_redir) chk("rand_flush_valid", 32'(insn_valid), 32'd0);
      if (redirect_valid) begin
        chk("rand_redir_rd_en", 32'(mem_rd_en), 32'd0);
        exp_pc = {redirect_addr, 2'b00};
      end else if (insn_valid && insn_ready) begin
        chk("rand_pc",   32'(insn_pc), 32'(exp_pc));
        chk("rand_data", insn_data,    ram[exp_pc[7:2]]);
        exp_pc = exp_pc + 8'd4;
        delivered++;
      end
      prev_redir = redirect_valid;
    end
    chk("rand_progress", 32'(delivered > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
